// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the raster test-pattern source.
//   MODE_*   : run-time pattern select codes (codes 6..7 decode as black)
//   BAR_RGB  : colour-bar table, entry n = {R,G,B} full-scale flags of bar n
package vga_pattern_pkg;

  localparam logic [2:0] MODE_BLACK   = 3'd0;
  localparam logic [2:0] MODE_RECT    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_BARS    = 3'd3;
  localparam logic [2:0] MODE_GRAD    = 3'd4;
  localparam logic [2:0] MODE_SOLID   = 3'd5;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  // Packed so BAR_RGB[n] selects bar n.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

endpackage

// File: rtl/vga_raster_counter.sv
// Raster x/y position counter.
//   clk_50, reset : clock, synchronous active-high reset
//   i_adv         : advance one pixel at the end of this cycle
//   i_sync        : restart at (0,0); wins over i_adv
//   o_x, o_y      : current raster position
//   o_last        : position is the frame's last pixel
//   o_origin      : position is (0,0)
module vga_raster_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  parameter int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clk_50,
  input  logic          reset,
  input  logic          i_adv,
  input  logic          i_sync,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last,
  output logic          o_origin
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_wrap, y_wrap;

  assign x_wrap = (x_q == X_LAST);
  assign y_wrap = (y_q == Y_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_sync) begin
      x_d = '0;
      y_d = '0;
    end else if (i_adv) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_last   = x_wrap & y_wrap;
  assign o_origin = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/vga_pattern_source.sv
// Raster test-pattern source: one RGB pixel per accepted request, raster order.
//   clk_50, reset          : clock, synchronous active-high reset
//   i_mode                 : pattern select (latched at the first pixel of a frame)
//   i_solid_rgb            : {R,G,B} for the solid pattern, used per pixel
//   i_req                  : request the next pixel
//   i_frame_sync           : restart raster at (0,0), drops same-cycle request
//   o_red/o_green/o_blue   : pixel colour (held while o_valid is low)
//   o_valid                : pixel on the outputs is new this cycle
//   o_x, o_y               : coordinates of the pixel on the outputs
//   o_frame_done           : pulses with the frame's last pixel
// H_ACTIVE must be a multiple of 8 for the colour bars to be evenly sized.
module vga_pattern_source
  import vga_pattern_pkg::*;
#(
  parameter int CW         = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int RECT_X0    = 2,
  parameter int RECT_X1    = 640,
  parameter int RECT_Y0    = 1,
  parameter int RECT_Y1    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 0,
  parameter int XW         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  parameter int YW         = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic            clk_50,
  input  logic            reset,
  input  logic [2:0]      i_mode,
  input  logic [3*CW-1:0] i_solid_rgb,
  input  logic            i_req,
  input  logic            i_frame_sync,
  output logic [CW-1:0]   o_red,
  output logic [CW-1:0]   o_green,
  output logic [CW-1:0]   o_blue,
  output logic            o_valid,
  output logic [XW-1:0]   o_x,
  output logic [YW-1:0]   o_y,
  output logic            o_frame_done
);

  localparam logic [31:0] FULL  = (32'd1 << CW) - 32'd1;
  localparam logic [31:0] BAR_W = 32'(H_ACTIVE / 8);
  localparam logic [31:0] RX0   = 32'(RECT_X0);
  localparam logic [31:0] RX1   = 32'(RECT_X1);
  localparam logic [31:0] RY0   = 32'(RECT_Y0);
  localparam logic [31:0] RY1   = 32'(RECT_Y1);

  logic          accept;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          cnt_last, cnt_origin;

  // Sync takes priority: the request in the same cycle is simply lost.
  assign accept = i_req & ~i_frame_sync;

  vga_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_cnt (
    .clk_50   (clk_50),
    .reset    (reset),
    .i_adv    (accept),
    .i_sync   (i_frame_sync),
    .o_x      (cnt_x),
    .o_y      (cnt_y),
    .o_last   (cnt_last),
    .o_origin (cnt_origin)
  );

  // Mode latch: the first pixel of a frame already uses the new mode, so the
  // incoming i_mode bypasses the register on that cycle.
  logic [2:0] mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (accept && cnt_origin) mode_d = i_mode;
  end

  always_ff @(posedge clk_50) begin
    if (reset) mode_q <= MODE_BLACK;
    else       mode_q <= mode_d;
  end

  // Pattern terms, all evaluated in 32-bit arithmetic so parameter values
  // wider than the coordinate never truncate.
  logic [31:0]   xw, yw, chk_xy, grad_raw, bar_raw;
  logic          in_rect, chk_on;
  logic [2:0]    bar_idx, bar_rgb;
  logic [CW-1:0] grad_lvl;

  assign xw       = 32'(cnt_x);
  assign yw       = 32'(cnt_y);
  assign in_rect  = (xw >= RX0) && (xw < RX1) && (yw >= RY0) && (yw < RY1);
  assign chk_xy   = (xw >> CHECK_LOG2) ^ (yw >> CHECK_LOG2);
  assign chk_on   = |(chk_xy & 32'd1);
  assign bar_raw  = xw / BAR_W;
  assign bar_idx  = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
  assign bar_rgb  = BAR_RGB[bar_idx];
  assign grad_raw = xw >> GRAD_SHIFT;
  assign grad_lvl = (grad_raw > FULL) ? CW'(FULL) : CW'(grad_raw);

  logic [CW-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (mode_d)
      MODE_RECT: begin
        pix_r = {CW{in_rect}};
        pix_g = {CW{in_rect}};
        pix_b = {CW{in_rect}};
      end
      MODE_CHECKER: begin
        pix_r = {CW{chk_on}};
        pix_g = {CW{chk_on}};
        pix_b = {CW{chk_on}};
      end
      MODE_BARS: begin
        pix_r = {CW{bar_rgb[2]}};
        pix_g = {CW{bar_rgb[1]}};
        pix_b = {CW{bar_rgb[0]}};
      end
      MODE_GRAD: begin
        pix_r = grad_lvl;
        pix_g = grad_lvl;
        pix_b = grad_lvl;
      end
      MODE_SOLID: begin
        pix_r = i_solid_rgb[3*CW-1:2*CW];
        pix_g = i_solid_rgb[2*CW-1:CW];
        pix_b = i_solid_rgb[CW-1:0];
      end
      default: ;  // black, including unused codes
    endcase
  end

  // Output stage: colour/coords only load on an accepted request.
  logic [CW-1:0] red_q, green_q, blue_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          valid_q, done_q;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= accept;
      done_q  <= accept & cnt_last;
      if (accept) begin
        red_q   <= pix_r;
        green_q <= pix_g;
        blue_q  <= pix_b;
        x_q     <= cnt_x;
        y_q     <= cnt_y;
      end
    end
  end

  assign o_red        = red_q;
  assign o_green      = green_q;
  assign o_blue       = blue_q;
  assign o_valid      = valid_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Bench for vga_pattern_source: three geometries driven by one stimulus
// stream, each checked against a pixel-index reference model via a queue.
module tb_vga_pattern_source;

  localparam int ND = 3;
  // Per-instance geometry: 0 = defaults, 1 = 8x2, 2 = 16x3 with narrow colour.
  localparam int P_H  [ND] = '{640, 8, 16};
  localparam int P_V  [ND] = '{480, 2, 3};
  localparam int P_CW [ND] = '{10, 10, 3};
  localparam int P_RX0[ND] = '{2, 2, 3};
  localparam int P_RX1[ND] = '{640, 6, 9};
  localparam int P_RY0[ND] = '{1, 1, 1};
  localparam int P_RY1[ND] = '{4, 2, 3};
  localparam int P_CL [ND] = '{5, 1, 2};
  localparam int P_GS [ND] = '{0, 0, 0};

  logic        clk_50 = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  i_mode = 3'd0;
  logic [29:0] i_solid_rgb = '0;
  logic        i_req = 1'b0;
  logic        i_frame_sync = 1'b0;

  always #5 clk_50 = ~clk_50;

  logic [9:0] r0, g0, b0, x0;
  logic [8:0] y0;
  logic       v0, fd0;
  logic [9:0] r1, g1, b1;
  logic [2:0] x1;
  logic [0:0] y1;
  logic       v1, fd1;
  logic [2:0] r2, g2, b2;
  logic [3:0] x2;
  logic [1:0] y2;
  logic       v2, fd2;

  vga_pattern_source u_dut0 (
    .clk_50(clk_50), .reset(reset), .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
    .i_req(i_req), .i_frame_sync(i_frame_sync), .o_red(r0), .o_green(g0), .o_blue(b0),
    .o_valid(v0), .o_x(x0), .o_y(y0), .o_frame_done(fd0));

  vga_pattern_source #(.CW(10), .H_ACTIVE(8), .V_ACTIVE(2), .RECT_X0(2), .RECT_X1(6),
    .RECT_Y0(1), .RECT_Y1(2), .CHECK_LOG2(1), .GRAD_SHIFT(0)) u_dut1 (
    .clk_50(clk_50), .reset(reset), .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
    .i_req(i_req), .i_frame_sync(i_frame_sync), .o_red(r1), .o_green(g1), .o_blue(b1),
    .o_valid(v1), .o_x(x1), .o_y(y1), .o_frame_done(fd1));

  vga_pattern_source #(.CW(3), .H_ACTIVE(16), .V_ACTIVE(3), .RECT_X0(3), .RECT_X1(9),
    .RECT_Y0(1), .RECT_Y1(3), .CHECK_LOG2(2), .GRAD_SHIFT(0)) u_dut2 (
    .clk_50(clk_50), .reset(reset), .i_mode(i_mode), .i_solid_rgb(i_solid_rgb[8:0]),
    .i_req(i_req), .i_frame_sync(i_frame_sync), .o_red(r2), .o_green(g2), .o_blue(b2),
    .o_valid(v2), .o_x(x2), .o_y(y2), .o_frame_done(fd2));

  typedef struct {
    bit          v;
    bit          fd;
    int unsigned x, y, r, g, b;
  } pix_t;

  pix_t        sbq  [ND][$];
  pix_t        held [ND];
  int unsigned mp   [ND];  // model raster position as a linear pixel index
  int unsigned mm   [ND];  // model latched mode
  int          total = 0;
  int          bad   = 0;

  // Reference colour for one pixel, straight from the pattern definitions.
  task automatic ref_colour(input int d, input int unsigned mode, input int unsigned x,
                            input int unsigned y, input logic [29:0] solid,
                            output int unsigned r, output int unsigned g, output int unsigned b);
    int unsigned full, lvl, idx;
    bit on;
    full = (1 << P_CW[d]) - 1;
    r = 0; g = 0; b = 0;
    case (mode)
      1: begin
        on = (x >= P_RX0[d]) && (x < P_RX1[d]) && (y >= P_RY0[d]) && (y < P_RY1[d]);
        if (on) begin r = full; g = full; b = full; end
      end
      2: begin
        if ((((x >> P_CL[d]) ^ (y >> P_CL[d])) % 2) == 1) begin r = full; g = full; b = full; end
      end
      3: begin
        idx = x / (P_H[d] / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: begin r = full; g = full; b = full; end  // white
          1: begin r = full; g = full;           end  // yellow
          2: begin           g = full; b = full; end  // cyan
          3: begin           g = full;           end  // green
          4: begin r = full;           b = full; end  // magenta
          5: begin r = full;                     end  // red
          6: begin                     b = full; end  // blue
          default: ;                                  // black
        endcase
      end
      4: begin
        lvl = x >> P_GS[d];
        if (lvl > full) lvl = full;
        r = lvl; g = lvl; b = lvl;
      end
      5: begin
        r = (int'(solid) >> (2 * P_CW[d])) & full;
        g = (int'(solid) >> P_CW[d]) & full;
        b = int'(solid) & full;
      end
      default: ;
    endcase
  endtask

  // One clock of stimulus: drive inputs and enqueue what each DUT must show
  // after the next rising edge.
  task automatic step(input bit rst, input bit req, input bit sync,
                      input logic [2:0] mode, input logic [29:0] solid);
    pix_t e;
    @(negedge clk_50);
    reset = rst; i_req = req; i_frame_sync = sync; i_mode = mode; i_solid_rgb = solid;
    for (int d = 0; d < ND; d++) begin
      e = held[d];
      e.v = 0; e.fd = 0;
      if (rst) begin
        mp[d] = 0; mm[d] = 0;
        e = '{0, 0, 0, 0, 0, 0, 0};
        held[d] = e;
      end else if (sync) begin
        mp[d] = 0;
      end else if (req) begin
        if (mp[d] == 0) mm[d] = mode;
        e.v  = 1;
        e.x  = mp[d] % P_H[d];
        e.y  = mp[d] / P_H[d];
        e.fd = (mp[d] == P_H[d] * P_V[d] - 1);
        ref_colour(d, mm[d], e.x, e.y, solid, e.r, e.g, e.b);
        mp[d] = (mp[d] + 1) % (P_H[d] * P_V[d]);
        held[d] = e;
      end
      sbq[d].push_back(e);
    end
  endtask

  function automatic pix_t actual(input int d);
    pix_t a;
    a = '{0, 0, 0, 0, 0, 0, 0};
    case (d)
      0: begin a.v = v0; a.fd = fd0; a.x = 32'(x0); a.y = 32'(y0);
               a.r = 32'(r0); a.g = 32'(g0); a.b = 32'(b0); end
      1: begin a.v = v1; a.fd = fd1; a.x = 32'(x1); a.y = 32'(y1);
               a.r = 32'(r1); a.g = 32'(g1); a.b = 32'(b1); end
      default: begin a.v = v2; a.fd = fd2; a.x = 32'(x2); a.y = 32'(y2);
               a.r = 32'(r2); a.g = 32'(g2); a.b = 32'(b2); end
    endcase
    return a;
  endfunction

  // Monitor: every cycle, pop one expectation per instance and compare.
  initial begin
    pix_t e, a;
    forever begin
      @(posedge clk_50);
      #1;
      for (int d = 0; d < ND; d++) begin
        if (sbq[d].size() > 0) begin
          e = sbq[d].pop_front();
          a = actual(d);
          total++;
          if (a != e) begin
            bad++;
            $display("FAIL dut%0d pixel @%0t: got v=%0d fd=%0d (%0d,%0d) rgb=%0h/%0h/%0h, want v=%0d fd=%0d (%0d,%0d) rgb=%0h/%0h/%0h",
                     d, $time, a.v, a.fd, a.x, a.y, a.r, a.g, a.b,
                     e.v, e.fd, e.x, e.y, e.r, e.g, e.b);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] md;
    for (int d = 0; d < ND; d++) begin
      mp[d] = 0; mm[d] = 0; held[d] = '{0, 0, 0, 0, 0, 0, 0};
    end

    // Reset
    repeat (3) step(1, 0, 0, 3'd0, '0);

    // Rectangle over three lines of the full-size frame
    repeat (3 * 640 + 3) step(0, 1, 0, 3'd1, 30'($urandom));

    // Colour bars from a fresh frame
    step(0, 1, 1, 3'd3, '0);
    repeat (700) step(0, 1, 0, 3'd3, 30'($urandom));

    // Checker, then a mid-frame switch to solid that must not take effect
    // until the raster restarts
    step(0, 0, 1, 3'd2, '0);
    repeat (6500) step(0, 1, 0, 3'd2, 30'($urandom));
    repeat (200) step(0, 1, 0, 3'd5, 30'($urandom));
    step(0, 1, 1, 3'd5, 30'($urandom));
    repeat (20) step(0, 1, 0, 3'd5, 30'($urandom));

    // Gradient, then sync together with a request mid-line
    step(0, 0, 1, 3'd4, '0);
    repeat (37 + 5 * 8) step(0, 1, 0, 3'd4, 30'($urandom));
    step(0, 1, 1, 3'd4, '0);
    repeat (40) step(0, 1, 0, 3'd4, 30'($urandom));

    // Mid-frame reset with a request pending
    step(1, 1, 0, 3'd3, '0);
    repeat (10) step(0, 1, 0, 3'd3, 30'($urandom));

    // Random traffic: gapped requests, occasional sync, mode churn, resets
    md = 3'($urandom);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) md = 3'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 59) == 0), md, 30'($urandom));
    end
    repeat (2) step(0, 0, 0, md, '0);

    repeat (3) @(posedge clk_50);
    #2;
    for (int d = 0; d < ND; d++) begin
      total++;
      if (sbq[d].size() != 0) begin
        bad++;
        $display("FAIL dut%0d drain: %0d expectations left, want 0", d, sbq[d].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
